// File: rtl/assoc_wt_cache_if.sv
// Hart-side request/response and backing-memory bus of the write-through cache.
// The slave modport is the cache; the master modport is the hart plus memory.
interface assoc_wt_cache_if;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;
  logic        o_busy;
  logic [31:0] i_req_addr;
  logic        i_req_ren;
  logic        i_req_wen;
  logic [3:0]  i_req_mask;
  logic [31:0] i_req_wdata;
  logic [31:0] o_res_rdata;

  modport slave (
    input  i_mem_ready, i_mem_rdata, i_mem_valid,
    input  i_req_addr, i_req_ren, i_req_wen, i_req_mask, i_req_wdata,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_busy, o_res_rdata
  );

  modport master (
    output i_mem_ready, i_mem_rdata, i_mem_valid,
    output i_req_addr, i_req_ren, i_req_wen, i_req_mask, i_req_wdata,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_busy, o_res_rdata
  );
endinterface

// File: rtl/assoc_wt_cache.sv
// N-way set-associative write-through / write-allocate cache with round-robin
// replacement, a one-set-per-cycle flush sweep and saturating hit/miss counters.
module assoc_wt_cache #(
  parameter int O     = 4,
  parameter int S     = 5,
  parameter int WAYS  = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  assoc_wt_cache_if.slave  bus,
  output logic [CNT_W-1:0] o_hit_count,
  output logic [CNT_W-1:0] o_miss_count
);
  localparam int LW   = 2**(O-2);
  localparam int SETS = 2**S;
  localparam int TW   = 32-O-S;
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OB   = (O > 2) ? O-2 : 1;

  typedef enum logic [2:0] {IDLE, REFILL, WRITE, RESP, FLUSH} state_t;

  function automatic logic [TW-1:0] f_tag(input logic [31:0] a);
    return TW'(a >> (O+S));
  endfunction

  function automatic logic [S-1:0] f_idx(input logic [31:0] a);
    return S'(a >> O);
  endfunction

  function automatic logic [OB-1:0] f_word(input logic [31:0] a);
    return (O > 2) ? OB'(a >> 2) : '0;
  endfunction

  function automatic logic [31:0] f_bmask(input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
    return r;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  m);
    return (old_w & ~f_bmask(m)) | (new_w & f_bmask(m));
  endfunction

  logic [31:0]           r_data [WAYS][SETS][LW];
  logic [TW-1:0]         r_tag  [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [SETS-1:0][WB-1:0]   r_rr;

  state_t            r_state, w_state_n;
  logic [31:0]       r_addr, r_wdata;
  logic              r_ren, r_outst, r_fpend;
  logic [3:0]        r_mask;
  logic [WB-1:0]     r_way;
  logic [OB-1:0]     r_cnt;
  logic [S-1:0]      r_fidx;
  logic [CNT_W-1:0]  r_hit, r_miss;

  logic [S-1:0]      w_idx, w_h_idx;
  logic [TW-1:0]     w_tag;
  logic [OB-1:0]     w_word, w_h_word;
  logic              w_hit;
  logic [WB-1:0]     w_hit_way, w_vict;
  logic [31:0]       w_hit_word, w_held_word, w_line;

  logic              w_we, w_tag_we, w_alloc, w_latch, w_hit_inc, w_miss_inc;
  logic [WB-1:0]     w_we_way, w_latch_way;
  logic [S-1:0]      w_we_idx;
  logic [OB-1:0]     w_we_word;
  logic [31:0]       w_we_data;

  assign w_idx       = f_idx(bus.i_req_addr);
  assign w_tag       = f_tag(bus.i_req_addr);
  assign w_word      = f_word(bus.i_req_addr);
  assign w_h_idx     = f_idx(r_addr);
  assign w_h_word    = f_word(r_addr);
  assign w_line      = r_addr & ~((32'd1 << O) - 32'd1);
  assign w_hit_word  = r_data[w_hit_way][w_idx][w_word];
  assign w_held_word = r_data[r_way][w_h_idx][w_h_word];

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_vict    = r_rr[w_idx];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WB'(w);
      end
      if (!r_valid[w_idx][w]) w_vict = WB'(w);
    end
  end

  always_comb begin
    w_state_n       = r_state;
    bus.o_mem_addr  = '0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_wdata = '0;
    bus.o_busy      = 1'b0;
    bus.o_res_rdata = '0;
    w_we        = 1'b0;
    w_we_way    = r_way;
    w_we_idx    = w_h_idx;
    w_we_word   = w_h_word;
    w_we_data   = f_merge(w_held_word, r_wdata, r_mask);
    w_tag_we    = 1'b0;
    w_alloc     = 1'b0;
    w_latch     = 1'b0;
    w_latch_way = w_vict;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_req_ren || bus.i_req_wen) begin
          if (!w_hit) begin
            bus.o_busy = 1'b1;
            w_miss_inc = 1'b1;
            w_latch    = 1'b1;
            w_state_n  = REFILL;
          end else if (bus.i_req_ren) begin
            bus.o_res_rdata = w_hit_word & f_bmask(bus.i_req_mask);
            w_hit_inc       = 1'b1;
          end else begin
            bus.o_mem_wen   = 1'b1;
            bus.o_mem_addr  = bus.i_req_addr;
            bus.o_mem_wdata = f_merge(w_hit_word, bus.i_req_wdata, bus.i_req_mask);
            w_hit_inc       = 1'b1;
            if (bus.i_mem_ready) begin
              w_we      = 1'b1;
              w_we_way  = w_hit_way;
              w_we_idx  = w_idx;
              w_we_word = w_word;
              w_we_data = bus.o_mem_wdata;
            end else begin
              bus.o_busy  = 1'b1;
              w_latch     = 1'b1;
              w_latch_way = w_hit_way;
              w_state_n   = WRITE;
            end
          end
        end else if (i_flush || r_fpend) begin
          w_state_n = FLUSH;
        end
      end
      REFILL: begin
        bus.o_busy = 1'b1;
        if (!r_outst) begin
          bus.o_mem_ren  = 1'b1;
          bus.o_mem_addr = w_line | (32'(r_cnt) << 2);
        end else if (bus.i_mem_valid) begin
          w_we      = 1'b1;
          w_we_word = r_cnt;
          w_we_data = bus.i_mem_rdata;
          w_tag_we  = (r_cnt == '0);
          if (r_cnt == OB'(LW-1)) begin
            w_alloc   = 1'b1;
            w_state_n = r_ren ? RESP : WRITE;
          end
        end
      end
      WRITE: begin
        bus.o_busy      = 1'b1;
        bus.o_mem_wen   = 1'b1;
        bus.o_mem_addr  = r_addr;
        bus.o_mem_wdata = w_we_data;
        if (bus.i_mem_ready) begin
          w_we      = 1'b1;
          w_state_n = RESP;
        end
      end
      RESP: begin
        bus.o_res_rdata = r_ren ? (w_held_word & f_bmask(r_mask)) : '0;
        w_state_n       = IDLE;
      end
      FLUSH: begin
        bus.o_busy = 1'b1;
        if (r_fidx == S'(SETS-1)) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_rr    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ren   <= 1'b0;
      r_mask  <= '0;
      r_way   <= '0;
      r_cnt   <= '0;
      r_outst <= 1'b0;
      r_fpend <= 1'b0;
      r_fidx  <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
    end else begin
      r_state <= w_state_n;
      r_fpend <= (r_fpend | i_flush) & ~((r_state == IDLE) && (w_state_n == FLUSH));
      if (w_latch) begin
        r_addr  <= bus.i_req_addr;
        r_ren   <= bus.i_req_ren;
        r_mask  <= bus.i_req_mask;
        r_wdata <= bus.i_req_wdata;
        r_way   <= w_latch_way;
        r_cnt   <= '0;
        r_outst <= 1'b0;
      end
      // One read in flight: issue, then wait for its data before the next word.
      if (r_state == REFILL) begin
        if (!r_outst && bus.i_mem_ready) begin
          r_outst <= 1'b1;
        end else if (r_outst && bus.i_mem_valid) begin
          r_outst <= 1'b0;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
      if (w_alloc) begin
        r_valid[w_h_idx][r_way] <= 1'b1;
        r_rr[w_h_idx] <= (r_rr[w_h_idx] == WB'(WAYS-1)) ? '0 : r_rr[w_h_idx] + 1'b1;
      end
      if (r_state == FLUSH) begin
        r_valid[r_fidx] <= '0;
        r_fidx          <= r_fidx + 1'b1;
      end
      if (w_hit_inc && (r_hit != '1))   r_hit  <= r_hit + 1'b1;
      if (w_miss_inc && (r_miss != '1)) r_miss <= r_miss + 1'b1;
    end
  end

  // Data and tags carry no reset; only the valid bits qualify them.
  always_ff @(posedge i_clk) begin
    if (w_we)     r_data[w_we_way][w_we_idx][w_we_word] <= w_we_data;
    if (w_tag_we) r_tag[r_way][w_h_idx] <= f_tag(r_addr);
  end

  assign o_hit_count  = r_hit;
  assign o_miss_count = r_miss;
endmodule

// File: tb/tb_assoc_wt_cache.sv
// Directed bench: word-granular memory model with one-cycle read latency,
// a shadow memory for expected data, and a scoreboard queue of read results.
module tb_assoc_wt_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] hitc, missc;
  int          errs = 0, checks = 0;
  int          nrd = 0, nwr = 0;
  logic [31:0] rd_log [0:255];
  logic        inj_valid = 1'b0;
  logic [31:0] wmem [int];
  logic [31:0] ref_w [int];
  logic [31:0] sb [$];

  assoc_wt_cache_if bus();

  assoc_wt_cache #(.O(4), .S(5), .WAYS(2), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus),
    .o_hit_count(hitc), .o_miss_count(missc)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] init_val(input int i);
    if (i == 32'h40) return 32'h11223344;
    return 32'h5A000000 ^ (32'(i) * 32'h00010203);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int i;
    i = int'(a[13:2]);
    return ref_w.exists(i) ? ref_w[i] : init_val(i);
  endfunction

  function automatic logic [31:0] bm(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Memory: accepts when ready, returns read data on the following cycle.
  always @(posedge clk) begin
    int i;
    bus.i_mem_valid <= inj_valid;
    i = int'(bus.o_mem_addr[13:2]);
    if (bus.o_mem_ren && bus.i_mem_ready) begin
      bus.i_mem_valid <= 1'b1;
      bus.i_mem_rdata <= wmem.exists(i) ? wmem[i] : init_val(i);
      rd_log[nrd[7:0]] = bus.o_mem_addr;
      nrd++;
    end
    if (bus.o_mem_wen && bus.i_mem_ready) begin
      wmem[i] = bus.o_mem_wdata;
      nwr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] m,
                    input bit exp_hit);
    int n0, n;
    n0 = nrd;
    sb.push_back(ref_rd(a) & bm(m));
    bus.i_req_addr = a;
    bus.i_req_mask = m;
    bus.i_req_ren  = 1'b1;
    @(negedge clk);
    chk({tag, " hit"}, 32'(!bus.o_busy), 32'(exp_hit));
    if (bus.o_busy) begin
      @(posedge clk); #1 bus.i_req_ren = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.o_busy && n < 200);
      chk({tag, " done"}, 32'(n < 200), 32'd1);
      chk({tag, " nreads"}, 32'(nrd - n0), 32'd4);
    end
    chk({tag, " data"}, bus.o_res_rdata, sb.pop_front());
    @(posedge clk); #1 bus.i_req_ren = 1'b0;
  endtask

  task automatic wr_hit(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m);
    logic [31:0] exp;
    exp = (ref_rd(a) & ~bm(m)) | (d & bm(m));
    ref_w[int'(a[13:2])] = exp;
    bus.i_req_addr = a; bus.i_req_wdata = d; bus.i_req_mask = m; bus.i_req_wen = 1'b1;
    @(negedge clk);
    chk({tag, " busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, " wen"}, 32'(bus.o_mem_wen), 32'd1);
    chk({tag, " addr"}, bus.o_mem_addr, a);
    chk({tag, " wdata"}, bus.o_mem_wdata, exp);
    @(posedge clk); #1 bus.i_req_wen = 1'b0;
  endtask

  initial begin
    int n0, w0, n;
    logic [31:0] wexp;
    bus.i_mem_ready = 1'b1;
    bus.i_req_addr = '0; bus.i_req_ren = 1'b0; bus.i_req_wen = 1'b0;
    bus.i_req_mask = '0; bus.i_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(bus.o_busy), 32'd0);
    chk("rst ren", 32'(bus.o_mem_ren), 32'd0);
    chk("rst wen", 32'(bus.o_mem_wen), 32'd0);
    chk("rst addr", bus.o_mem_addr, 32'd0);
    chk("rst wdata", bus.o_mem_wdata, 32'd0);
    chk("rst rdata", bus.o_res_rdata, 32'd0);
    chk("rst hits", 32'(hitc), 32'd0);
    chk("rst misses", 32'(missc), 32'd0);
    @(posedge clk); #1;

    // Cold miss then same-line hit
    n0 = nrd;
    rd("cold 100", 32'h100, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("refill addr %0d", k), rd_log[8'(n0 + k)], 32'h100 + 32'(4*k));
    chk("miss cnt 1", 32'(missc), 32'd1);
    rd("hit 104", 32'h104, 4'hF, 1'b1);
    chk("hit cnt 1", 32'(hitc), 32'd1);

    // Write hit with byte mask, then read back
    wr_hit("wr 100", 32'h100, 32'hAABBCCDD, 4'b0010);
    rd("rb 100", 32'h100, 4'hF, 1'b1);
    chk("rb value", 32'h1122CC44, ref_rd(32'h100));
    rd("mask 108", 32'h108, 4'b0101, 1'b1);

    // Round-robin eviction within set 0
    rd("fill 000", 32'h000, 4'hF, 1'b0);
    rd("fill 200", 32'h200, 4'hF, 1'b0);
    rd("fill 400", 32'h400, 4'hF, 1'b0);
    rd("fill 600", 32'h600, 4'hF, 1'b0);
    rd("keep 400", 32'h404, 4'hF, 1'b1);
    rd("keep 600", 32'h608, 4'hF, 1'b1);
    rd("evict 000", 32'h000, 4'hF, 1'b0);
    chk("cnt hit", 32'(hitc), 32'd6);
    chk("cnt miss", 32'(missc), 32'd6);

    // Write miss with memory stalling the write
    wexp = (ref_rd(32'h3000) & 32'h0000FFFF) | (32'hCAFEF00D & 32'hFFFF0000);
    ref_w[int'(32'h3000 >> 2)] = wexp;
    n0 = nrd; w0 = nwr;
    bus.i_req_addr = 32'h3000; bus.i_req_wdata = 32'hCAFEF00D;
    bus.i_req_mask = 4'b1100; bus.i_req_wen = 1'b1;
    @(negedge clk);
    chk("wmiss busy", 32'(bus.o_busy), 32'd1);
    @(posedge clk); #1 bus.i_req_wen = 1'b0;
    n = 0;
    while (nrd < n0 + 4 && n < 100) begin @(posedge clk); #1 n++; end
    bus.i_mem_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_mem_wen && n < 100);
    chk("wmiss reach write", 32'(bus.o_mem_wen), 32'd1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("stall busy %0d", c), 32'(bus.o_busy), 32'd1);
      chk($sformatf("stall wdata %0d", c), bus.o_mem_wdata, wexp);
      chk($sformatf("stall addr %0d", c), bus.o_mem_addr, 32'h3000);
    end
    @(posedge clk); #1 bus.i_mem_ready = 1'b1;
    @(negedge clk);
    chk("wmiss wen", 32'(bus.o_mem_wen), 32'd1);
    @(posedge clk); #1;
    chk("wmiss one write", 32'(nwr - w0), 32'd1);
    @(negedge clk);
    chk("wmiss resp busy", 32'(bus.o_busy), 32'd0);
    chk("wmiss resp data", bus.o_res_rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wmiss idle wen", 32'(bus.o_mem_wen), 32'd0);
    chk("wmiss writes", 32'(nwr - w0), 32'd1);
    @(posedge clk); #1;
    rd("rb 3000", 32'h3000, 4'hF, 1'b1);
    chk("cnt hit 2", 32'(hitc), 32'd7);
    chk("cnt miss 2", 32'(missc), 32'd7);

    // Flush sweep
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    n = 0;
    repeat (40) begin @(negedge clk); if (bus.o_busy) n++; end
    chk("flush cycles", 32'(n), 32'd32);
    chk("flush hits", 32'(hitc), 32'd7);
    chk("flush misses", 32'(missc), 32'd7);
    @(posedge clk); #1;
    rd("post flush 104", 32'h104, 4'hF, 1'b0);
    rd("post flush 3000", 32'h3000, 4'hF, 1'b0);
    rd("post flush 600", 32'h600, 4'hF, 1'b0);

    // Reset during the second refill word
    n0 = nrd;
    bus.i_req_addr = 32'h800; bus.i_req_mask = 4'hF; bus.i_req_ren = 1'b1;
    @(negedge clk);
    chk("rst miss busy", 32'(bus.o_busy), 32'd1);
    @(posedge clk); #1 bus.i_req_ren = 1'b0;
    n = 0;
    while (nrd < n0 + 2 && n < 100) begin @(posedge clk); #1 n++; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; inj_valid = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(bus.o_busy), 32'd0);
    chk("abort ren", 32'(bus.o_mem_ren), 32'd0);
    chk("abort addr", bus.o_mem_addr, 32'd0);
    chk("abort hits", 32'(hitc), 32'd0);
    chk("abort misses", 32'(missc), 32'd0);
    @(posedge clk); #1 inj_valid = 1'b0;
    n0 = nrd;
    @(negedge clk);
    chk("late valid busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late valid ren", 32'(bus.o_mem_ren), 32'd0);
    chk("late valid reads", 32'(nrd - n0), 32'd0);
    @(posedge clk); #1;
    n0 = nrd;
    rd("refetch 800", 32'h800, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("refetch addr %0d", k), rd_log[8'(n0 + k)], 32'h800 + 32'(4*k));
    chk("refetch misses", 32'(missc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
